// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant; default is single-entry.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Readiness depends only on held state, breaking the out_ready->in_ready path.
    assign in_ready = !flush && (state_q != ST_TWO);
`else
    assign in_ready = !flush && (!valid_q || out_ready);
`endif

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        stall_d = stall_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (valid_q && !out_ready && !flush && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        // Flush wins over any concurrent transfer; out_data keeps its last value.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
`else
                    if (in_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        occ_d   = 2'(state_d);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
            main_q  <= '0;
            stall_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
            main_q  <= main_d;
            stall_q <= stall_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (any packed stage struct, ≥1).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width in bits (≥2).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream stage offers in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a live instruction.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: registered payload to the downstream stage.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes out_data this cycle.
REQ-011 The block SHALL have port flush, input, 1 bit: squash all held entries (branch/jump resolve).
REQ-012 The block SHALL have port occupancy, output, 2 bits: number of held entries (0..2).
REQ-013 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of stall cycles.

Function
REQ-014 An input transfer SHALL occur on an edge where in_valid && in_ready; an output transfer SHALL occur on an edge where out_valid && out_ready.
REQ-015 The latency from an input transfer into an empty block SHALL be 1 cycle, with out_valid=1 and out_data=in_data on the following cycle.
REQ-016 Entries SHALL leave in arrival order, with no duplication or loss except on flush.
REQ-017 When out_valid=0, out_data SHALL hold its last value, and downstream SHALL ignore it.
REQ-018 While flush=1, in_ready SHALL be 0 (combinational), and on that edge all entries SHALL be invalidated, the occupancy SHALL go to 0, and any in_data offered SHALL be dropped.
REQ-019 flush SHALL have priority over a simultaneous input or output transfer, and an output transfer in the flush cycle SHALL still count as consumed by downstream.
REQ-020 The stall_cnt register SHALL increment by 1 on every edge with out_valid=1, out_ready=0 and flush=0, and SHALL saturate at all-ones without wrapping.
REQ-021 The stall_cnt register SHALL be cleared only by reset, and SHALL not be cleared by flush.
REQ-022 The occupancy output SHALL be registered and SHALL equal the state encoding: EMPTY=0, ONE=1, TWO=2.
REQ-023 In single-entry mode, the state SHALL be EMPTY or ONE; in_ready SHALL equal !flush && (!out_valid || out_ready); and the block SHALL move EMPTY→ONE on an input transfer, ONE→EMPTY on an output transfer without an input transfer, and stay ONE when both transfer (data replaced).
REQ-024 In skid mode, the state SHALL be EMPTY, ONE or TWO, with a main register driving out_data and a skid register behind it.
REQ-025 In skid mode, in_ready SHALL equal !flush && (state != TWO), depending only on state and flush, not on out_ready.
REQ-026 In skid mode, the state SHALL change as follows:
- EMPTY→ONE on an input transfer.
- ONE→TWO on an input transfer without an output transfer; the input is written to skid.
- ONE→ONE on both an input and an output transfer; main is loaded with the input.
- ONE→EMPTY on an output transfer only.
- TWO→ONE on an output transfer; skid moves to main.
REQ-027 The block SHALL never accept an input in state TWO.

Reset
REQ-028 While nRST=0, state SHALL be EMPTY, out_valid=0, out_data=0, the skid register=0, occupancy=0 and stall_cnt=0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, and in_ready SHALL be 1 (if flush=0) from the first cycle after nRST rises.

Configuration
REQ-030 The macro PIPE_STAGE_SKID_EN SHALL select skid mode when defined: two entries, per REQ-024 to REQ-027, with no combinational out_ready→in_ready path.
REQ-031 When PIPE_STAGE_SKID_EN is undefined, the block SHALL be single-entry per REQ-023, the occupancy output SHALL never exceed 1, and the skid register SHALL not be synthesised.

Verification
REQ-032 The bench SHALL cover: after reset, in_valid=1, in_data=0x1234_5678, out_ready=1 -> next cycle out_valid=1 and out_data=0x1234_5678; outputs were 0 during reset.
REQ-033 The bench SHALL cover: skid mode, out_ready=0, inputs 0xA then 0xB -> occupancy=2 and in_ready=0; then out_ready=1 for 2 cycles -> outputs 0xA then 0xB, occupancy 0.
REQ-034 The bench SHALL cover: single-entry mode, out_ready=0 with a held entry -> in_ready=0 the same cycle; out_ready=1 with in_valid=1 -> in_ready=1 and the entry is replaced with no bubble.
REQ-035 The bench SHALL cover: flush=1 in state TWO together with in_valid=1 -> in_ready=0, then next cycle out_valid=0 and occupancy=0, with the offered word never appearing at the output.
REQ-036 The bench SHALL cover: CNT_W=2, out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt goes 1,2,3,3,3, then stays 3 after flush.
REQ-037 The bench SHALL cover: nRST pulsed low mid-transfer in state TWO -> out_valid=0 and stall_cnt=0 asynchronously, and in_ready=1 after release.
